fb_sprite_writer: RTL

- Writer side of the 320x240x12-bit video-buffer SRAM that the VGA pixel path reads.
- Copies one rectangular sprite from a sprite ROM into the frame buffer at a given position.
- Skips colour-key pixels (12'h0F0) and clips at the buffer edges.
- Runs on the system clock; a game-logic FSM starts it once per object during the idle/blank phase.

---
 rtl/fb_sprite_writer_if.sv | 33 +++
 rtl/fb_sprite_writer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_sprite_writer_if.sv
// Bus bundle between the sprite writer and its environment.
//   master: request side (start, sprite geometry, destination), ROM data return,
//           frame-buffer arbiter grant; observes the ROM address, write port and status.
//   slave : the sprite writer itself.
interface fb_sprite_writer_if #(
    parameter int unsigned SPR_AW = 14,
    parameter int unsigned FB_AW  = 17
);
    logic              start;
    logic [SPR_AW-1:0] spr_base;
    logic [7:0]        spr_w;
    logic [7:0]        spr_h;
    logic [9:0]        dst_x;
    logic [9:0]        dst_y;
    logic              fb_ready;
    logic [SPR_AW-1:0] spr_addr;
    logic [11:0]       spr_data;
    logic              fb_we;
    logic [FB_AW-1:0]  fb_addr;
    logic [11:0]       fb_data;
    logic              busy;
    logic              done;

    modport master (
        output start, spr_base, spr_w, spr_h, dst_x, dst_y, fb_ready, spr_data,
        input  spr_addr, fb_we, fb_addr, fb_data, busy, done
    );

    modport slave (
        input  start, spr_base, spr_w, spr_h, dst_x, dst_y, fb_ready, spr_data,
        output spr_addr, fb_we, fb_addr, fb_data, busy, done
    );
endinterface

// File: rtl/fb_sprite_writer.sv
// Sprite-to-frame-buffer copy engine.
// Reads a W x H sprite row-major from a synchronous ROM and writes it into the
// FB_W x FB_H video buffer at (dst_x, dst_y), skipping colour-key pixels and
// clipping anything that lands past the right or bottom edge.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   wr_if.slave - request, ROM read port, frame-buffer write port, busy/done
// The write strobe, address and data are decided in the write slot itself,
// because ROM data for that slot only arrives in that cycle; the address and
// data hold their last written values whenever no write is issued.
module fb_sprite_writer #(
    parameter int unsigned FB_W   = 320,
    parameter int unsigned FB_H   = 240,
    parameter int unsigned FB_AW  = 17,
    parameter int unsigned SPR_AW = 14,
    parameter logic [11:0] KEY    = 12'h0F0
) (
    input  logic              clk,
    input  logic              reset,
    fb_sprite_writer_if.slave wr_if
);

    localparam int unsigned CW = 11;   // clip-test coordinate width, no wrap

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        w_q, w_d, h_q, h_d;
    logic [9:0]        dx_q, dx_d, dy_q, dy_d;
    logic [7:0]        i_q, i_d, j_q, j_d;
    logic [SPR_AW-1:0] spr_addr_q, spr_addr_d;
    logic              pv_q, pv_d;
    logic [CW-1:0]     px_q, px_d, py_q, py_d;
    logic              stall_q, stall_d;
    logic [11:0]       hold_q, hold_d;
    logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
    logic [11:0]       fb_data_q, fb_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              slot_c;
    logic              last_c;
    logic              in_bounds_c;
    logic              we_c;
    logic [11:0]       pix_c;
    logic [FB_AW-1:0]  addr_c;

    // Write-slot evaluation for the pixel held in the pipeline register.
    // While stalled the ROM already shows the next address's data, so the
    // pixel seen on the first stalled cycle is parked in hold_q and reused.
    always_comb begin
        slot_c      = ((state_q == S_READ) && pv_q) || (state_q == S_DRAIN);
        pix_c       = stall_q ? hold_q : wr_if.spr_data;
        in_bounds_c = (px_q < CW'(FB_W)) && (py_q < CW'(FB_H));
        addr_c      = FB_AW'(FB_AW'(py_q) * FB_AW'(FB_W)) + FB_AW'(px_q);
        we_c        = slot_c && (pix_c != KEY) && in_bounds_c && wr_if.fb_ready;
        last_c      = (i_q == w_q - 8'd1) && (j_q == h_q - 8'd1);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        i_d        = i_q;
        j_d        = j_q;
        spr_addr_d = spr_addr_q;
        pv_d       = pv_q;
        px_d       = px_q;
        py_d       = py_q;
        stall_d    = slot_c && !wr_if.fb_ready;
        hold_d     = hold_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;

        if (slot_c && !wr_if.fb_ready && !stall_q) begin
            hold_d = wr_if.spr_data;
        end

        if (we_c) begin
            fb_addr_d = addr_c;
            fb_data_d = pix_c;
        end

        unique case (state_q)
            S_IDLE: begin
                if (wr_if.start) begin
                    w_d        = wr_if.spr_w;
                    h_d        = wr_if.spr_h;
                    dx_d       = wr_if.dst_x;
                    dy_d       = wr_if.dst_y;
                    i_d        = 8'd0;
                    j_d        = 8'd0;
                    pv_d       = 1'b0;
                    spr_addr_d = wr_if.spr_base;
                    if ((wr_if.spr_w == 8'd0) || (wr_if.spr_h == 8'd0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                if (wr_if.fb_ready) begin
                    // Capture destination coordinates of the pixel being read.
                    pv_d = 1'b1;
                    px_d = CW'(dx_q) + CW'(i_q);
                    py_d = CW'(dy_q) + CW'(j_q);
                    if (last_c) begin
                        state_d = S_DRAIN;
                    end else begin
                        // Row-major and contiguous: the next pixel is one word on.
                        spr_addr_d = spr_addr_q + SPR_AW'(1);
                        if (i_q == w_q - 8'd1) begin
                            i_d = 8'd0;
                            j_d = j_q + 8'd1;
                        end else begin
                            i_d = i_q + 8'd1;
                        end
                    end
                end
            end

            S_DRAIN: begin
                if (wr_if.fb_ready) begin
                    pv_d    = 1'b0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags follow the state being entered so they line up with it.
    always_comb begin
        busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            i_q        <= '0;
            j_q        <= '0;
            spr_addr_q <= '0;
            pv_q       <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            stall_q    <= 1'b0;
            hold_q     <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            i_q        <= i_d;
            j_q        <= j_d;
            spr_addr_q <= spr_addr_d;
            pv_q       <= pv_d;
            px_q       <= px_d;
            py_q       <= py_d;
            stall_q    <= stall_d;
            hold_q     <= hold_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wr_if.spr_addr = spr_addr_q;
    assign wr_if.busy     = busy_q;
    assign wr_if.done     = done_q;
    assign wr_if.fb_we    = we_c;
    assign wr_if.fb_addr  = we_c ? addr_c : fb_addr_q;
    assign wr_if.fb_data  = we_c ? pix_c : fb_data_q;

endmodule
